// File: rtl/ctrl_incdec_seq.sv
// ctrl_incdec_seq: sequential +/-1 adjuster for exponent fields.
// Works through the operand CHUNK bits per clock and stops as soon as the
// carry (increment) or borrow (decrement) dies out.
// Optional build macro: CTRL_INCDEC_SATURATE_EN clamps an overflow to all
// ones and an underflow to zero instead of wrapping.
module ctrl_incdec_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en,
  input  logic             dec,
  input  logic [WIDTH-1:0] z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             ovf,
  output logic             unf,
  output logic             busy
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [KW-1:0]    k;
  logic             carry;
  logic             dec_q;

  int               lo;
  logic [CHUNK-1:0] cur;
  logic [CHUNK:0]   step;

  // Adds or subtracts the incoming carry on one chunk; the top bit of the
  // result is the carry-out (inc) or borrow-out (dec).
  function automatic logic [CHUNK:0] chunk_step(input logic [CHUNK-1:0] c,
                                                input logic cin,
                                                input logic d);
    logic [CHUNK:0] ext;
    logic [CHUNK:0] cx;
    ext = {1'b0, c};
    cx  = {{CHUNK{1'b0}}, cin};
    if (d) chunk_step = ext - cx;
    else   chunk_step = ext + cx;
  endfunction

`ifdef CTRL_INCDEC_SATURATE_EN
  // Clamp value once the carry/borrow runs off the MSB: Inf pattern or zero.
  function automatic logic [WIDTH-1:0] sat_value(input logic d);
    sat_value = d ? '0 : '1;
  endfunction
`endif

  // Ready depends on state only; forced low while reset is held.
  assign in_ready = rst_n && (state == S_IDLE);
  assign out      = work;

  // Select the chunk being worked on and compute its adjusted value.
  always_comb begin
    lo   = int'(k) * CHUNK;
    cur  = work[lo +: CHUNK];
    step = chunk_step(cur, carry, dec_q);
  end

  // Control FSM with registered outputs; the working register doubles as out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      work      <= '0;
      k         <= '0;
      carry     <= 1'b0;
      dec_q     <= 1'b0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            work      <= z;
            dec_q     <= dec;
            k         <= '0;
            carry     <= 1'b1;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            out_valid <= 1'b0;
            if (en) begin
              state <= S_RUN;
              busy  <= 1'b1;
            end else begin
              // Pass-through: out_valid rises on the following edge.
              state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          work[lo +: CHUNK] <= step[CHUNK-1:0];
          carry             <= step[CHUNK];
          if (!step[CHUNK]) begin
            // Carry died: higher chunks are untouched and already correct.
            state     <= S_DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else if (k == KLAST) begin
            ovf <= !dec_q;
            unf <= dec_q;
`ifdef CTRL_INCDEC_SATURATE_EN
            work <= sat_value(dec_q);
`endif
            state     <= S_DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
